// File: rtl/digdug_cus06_pkg.sv
// Shared types and constants for the CUS06 custom-chip bus controller.
//   state_t     : transfer FSM states
//   ctrl_t      : field view of the 8-bit control register
//   NMI_INHIBIT : control value that parks the NMI timer
//   IDX_W       : width of the device register index counter
package digdug_cus06_pkg;

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CHIP_N   = 4;
  localparam int unsigned PERIOD_W = 3;

  localparam logic [DATA_W-1:0] NMI_INHIBIT = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Control register layout: {period[2:0], dir, mask[3:0]}; dir=1 means read.
  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic                dir;
    logic [CHIP_N-1:0]   mask;
  } ctrl_t;

  // Lowest selected chip wins a multi-select read.
  function automatic logic [1:0] lowest_chip(input logic [CHIP_N-1:0] mask);
    logic [1:0] sel;
    sel = 2'd3;
    if (mask[0])      sel = 2'd0;
    else if (mask[1]) sel = 2'd1;
    else if (mask[2]) sel = 2'd2;
    return sel;
  endfunction

endpackage

// File: rtl/digdug_cus06_nmi_timer.sv
// Periodic NMI generator.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the timer (control write)
//   en         : timer running; when low everything is held at zero
//   period     : NMI period in ticks of TICK_DIV cycles (nonzero when en)
//   nmi        : registered NMI pulse, NMI_W cycles wide
module digdug_cus06_nmi_timer
  import digdug_cus06_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2400,
  parameter int unsigned NMI_W    = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                nmi
);

  localparam int unsigned TICK_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW_CW   = (NMI_W > 1) ? $clog2(NMI_W) : 1;

  logic [TICK_CW-1:0]  tick_cnt;
  logic [PERIOD_W-1:0] tick_num;
  logic [PW_CW-1:0]    pw_cnt;
  logic                tick_wrap;
  logic                fire;

  // A tick ends every TICK_DIV cycles; the NMI fires on the period-th tick.
  always_comb begin
    tick_wrap = (tick_cnt == TICK_CW'(TICK_DIV - 1));
    fire      = tick_wrap && (tick_num == PERIOD_W'(period - PERIOD_W'(1)));
  end

  // Prescaler, tick counter and pulse-width counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick_num <= '0;
      pw_cnt   <= '0;
      nmi      <= 1'b0;
    end else if (clr || !en) begin
      tick_cnt <= '0;
      tick_num <= '0;
      pw_cnt   <= '0;
      nmi      <= 1'b0;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_CW'(1);
      if (tick_wrap) begin
        tick_num <= fire ? '0 : tick_num + PERIOD_W'(1);
      end
      if (fire) begin
        nmi    <= 1'b1;
        pw_cnt <= PW_CW'(NMI_W - 1);
      end else if (nmi) begin
        if (pw_cnt == '0) begin
          nmi <= 1'b0;
        end else begin
          pw_cnt <= pw_cnt - PW_CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/digdug_cus06_ctrl.sv
// CUS06 custom-chip bus controller: CPU control/data windows, device
// transfer sequencer (SETUP/STROBE/HOLD) and periodic NMI.
//   CL, RESET_N           : clock, async active-low reset
//   CS_CTL, CS_DAT, WR, RD, DI : CPU access; DO read data (registered)
//   BUSY, NMI             : transfer in progress, periodic NMI request
//   DEV_CS/WR/RD/AD/DO    : device chip selects, strobes, index, write data
//   DEV_DI0..DEV_DI3      : per-chip read data
// Build option: CUS06_CTRL_READBACK_EN makes CS_CTL reads return CTRL.
module digdug_cus06_ctrl
  import digdug_cus06_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2400,
  parameter int unsigned NMI_W    = 200,
  parameter int unsigned STB_W    = 2
) (
  input  logic        CL,
  input  logic        RESET_N,
  input  logic        CS_CTL,
  input  logic        CS_DAT,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        BUSY,
  output logic        NMI,
  output logic [3:0]  DEV_CS,
  output logic        DEV_WR,
  output logic        DEV_RD,
  output logic [3:0]  DEV_AD,
  output logic [7:0]  DEV_DO,
  input  logic [7:0]  DEV_DI0,
  input  logic [7:0]  DEV_DI1,
  input  logic [7:0]  DEV_DI2,
  input  logic [7:0]  DEV_DI3
);

  localparam int unsigned STB_CW = (STB_W > 1) ? $clog2(STB_W) : 1;

  state_t              state, state_n;
  logic [DATA_W-1:0]   ctrl;
  ctrl_t               cf;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [STB_CW-1:0]   stb_cnt, stb_cnt_n;
  logic [DATA_W-1:0]   rdata, rdata_n;
  logic [DATA_W-1:0]   sel_di;

  logic                ctl_wr;
  logic                dat_acc;
  logic                start;
  logic                rd_latch;
  logic                xfer;
  logic                nmi_en;

  logic                busy_n;
  logic [CHIP_N-1:0]   dev_cs_n;
  logic                dev_wr_n;
  logic                dev_rd_n;
  logic [IDX_W-1:0]    dev_ad_n;
  logic [DATA_W-1:0]   dev_do_n;
  logic [DATA_W-1:0]   do_n;

  assign cf      = ctrl_t'(ctrl);
  assign ctl_wr  = CS_CTL & WR;
  assign dat_acc = CS_DAT & (WR | RD);
  assign nmi_en  = (cf.period != '0) && (ctrl != NMI_INHIBIT);

  // Read data source for the lowest selected chip.
  always_comb begin
    sel_di = DEV_DI3;
    case (lowest_chip(cf.mask))
      2'd0:    sel_di = DEV_DI0;
      2'd1:    sel_di = DEV_DI1;
      2'd2:    sel_di = DEV_DI2;
      default: sel_di = DEV_DI3;
    endcase
  end

  // Next state and next registered outputs; a control write overrides all.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    stb_cnt_n = stb_cnt;
    start     = 1'b0;
    rd_latch  = 1'b0;

    if (ctl_wr) begin
      state_n   = ST_IDLE;
      idx_n     = '0;
      stb_cnt_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dat_acc && (cf.mask != '0)) begin
            state_n = ST_SETUP;
            start   = 1'b1;
          end
        end
        ST_SETUP: begin
          state_n   = ST_STROBE;
          stb_cnt_n = '0;
        end
        ST_STROBE: begin
          if (stb_cnt == STB_CW'(STB_W - 1)) begin
            state_n  = ST_HOLD;
            rd_latch = cf.dir;
          end else begin
            stb_cnt_n = stb_cnt + STB_CW'(1);
          end
        end
        ST_HOLD: begin
          state_n = ST_IDLE;
          idx_n   = idx + IDX_W'(1);
        end
        default: state_n = ST_IDLE;
      endcase
    end

    xfer     = (state_n != ST_IDLE);
    busy_n   = xfer;
    dev_cs_n = xfer ? cf.mask : '0;
    dev_ad_n = xfer ? idx : '0;
    // Write data is captured at the access and held for the whole transfer.
    dev_do_n = start ? DI : (xfer ? DEV_DO : '0);
    dev_wr_n = (state_n == ST_STROBE) && !cf.dir;
    dev_rd_n = (state_n == ST_STROBE) &&  cf.dir;
    rdata_n  = rd_latch ? sel_di : rdata;

    do_n = 8'hFF;
    if (CS_CTL && RD) begin
`ifdef CUS06_CTRL_READBACK_EN
      do_n = ctrl;
`else
      do_n = 8'hFF;
`endif
    end else if (CS_DAT && RD && (cf.mask != '0)) begin
      do_n = rdata;
    end
  end

  // State, control, index and output registers.
  always_ff @(posedge CL or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      ctrl    <= '0;
      idx     <= '0;
      stb_cnt <= '0;
      rdata   <= 8'hFF;
      BUSY    <= 1'b0;
      DEV_CS  <= '0;
      DEV_WR  <= 1'b0;
      DEV_RD  <= 1'b0;
      DEV_AD  <= '0;
      DEV_DO  <= '0;
      DO      <= 8'hFF;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      stb_cnt <= stb_cnt_n;
      rdata   <= rdata_n;
      if (ctl_wr) begin
        ctrl <= DI;
      end
      BUSY    <= busy_n;
      DEV_CS  <= dev_cs_n;
      DEV_WR  <= dev_wr_n;
      DEV_RD  <= dev_rd_n;
      DEV_AD  <= dev_ad_n;
      DEV_DO  <= dev_do_n;
      DO      <= do_n;
    end
  end

  digdug_cus06_nmi_timer #(
    .TICK_DIV (TICK_DIV),
    .NMI_W    (NMI_W)
  ) u_nmi_timer (
    .clk    (CL),
    .rst_n  (RESET_N),
    .clr    (ctl_wr),
    .en     (nmi_en),
    .period (cf.period),
    .nmi    (NMI)
  );

endmodule

// File: tb/tb_digdug_cus06_ctrl.sv
// Directed bench for digdug_cus06_ctrl.
module tb_digdug_cus06_ctrl;

  logic       CL;
  logic       RESET_N;
  logic       CS_CTL, CS_DAT, WR, RD;
  logic [7:0] DI, DO;
  logic       BUSY, NMI;
  logic [3:0] DEV_CS, DEV_AD;
  logic       DEV_WR, DEV_RD;
  logic [7:0] DEV_DO;
  logic [7:0] DEV_DI0, DEV_DI1, DEV_DI2, DEV_DI3;

  int vectors     = 0;
  int miscompares = 0;

`ifdef CUS06_CTRL_READBACK_EN
  localparam logic [7:0] RB_AFTER_RESET = 8'h00;
`else
  localparam logic [7:0] RB_AFTER_RESET = 8'hFF;
`endif

  digdug_cus06_ctrl #(
    .TICK_DIV (2400),
    .NMI_W    (200),
    .STB_W    (2)
  ) dut (
    .CL      (CL),
    .RESET_N (RESET_N),
    .CS_CTL  (CS_CTL),
    .CS_DAT  (CS_DAT),
    .WR      (WR),
    .RD      (RD),
    .DI      (DI),
    .DO      (DO),
    .BUSY    (BUSY),
    .NMI     (NMI),
    .DEV_CS  (DEV_CS),
    .DEV_WR  (DEV_WR),
    .DEV_RD  (DEV_RD),
    .DEV_AD  (DEV_AD),
    .DEV_DO  (DEV_DO),
    .DEV_DI0 (DEV_DI0),
    .DEV_DI1 (DEV_DI1),
    .DEV_DI2 (DEV_DI2),
    .DEV_DI3 (DEV_DI3)
  );

  initial CL = 1'b0;
  always #5 CL = ~CL;

  task automatic tick();
    @(posedge CL);
    #1;
  endtask

  task automatic idle_inputs();
    CS_CTL = 1'b0; CS_DAT = 1'b0; WR = 1'b0; RD = 1'b0; DI = 8'h00;
  endtask

  task automatic ctl_write(input logic [7:0] d);
    CS_CTL = 1'b1; WR = 1'b1; DI = d;
    tick();
    idle_inputs();
  endtask

  task automatic dat_write(input logic [7:0] d);
    CS_DAT = 1'b1; WR = 1'b1; DI = d;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    idle_inputs();
    tick(); tick();
    vectors++;
    if (NMI !== 1'b0 || BUSY !== 1'b0 || DEV_CS !== 4'h0 || DEV_WR !== 1'b0 ||
        DEV_RD !== 1'b0 || DEV_AD !== 4'h0 || DEV_DO !== 8'h00 || DO !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_outputs: nmi=%b busy=%b cs=%h wr=%b rd=%b ad=%h ddo=%h do=%h, expected 0 0 0 0 0 0 00 ff",
               NMI, BUSY, DEV_CS, DEV_WR, DEV_RD, DEV_AD, DEV_DO, DO);
    end
    RESET_N = 1'b1;
    tick();
    CS_CTL = 1'b1; RD = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (DO !== RB_AFTER_RESET) begin
      miscompares++;
      $display("FAIL reset_readback: got %h expected %h", DO, RB_AFTER_RESET);
    end
  endtask

  task automatic test_write();
    int busy_cnt;
    int wr_cnt;
    ctl_write(8'h01);
    for (int i = 0; i < 3; i++) begin
      dat_write(8'hA5);
      vectors++;
      if (DEV_CS !== 4'h1 || DEV_AD !== 4'(i) || DEV_DO !== 8'hA5 || BUSY !== 1'b1 || DEV_WR !== 1'b0) begin
        miscompares++;
        $display("FAIL write_setup[%0d]: cs=%h ad=%h ddo=%h busy=%b wr=%b, expected 1 %h a5 1 0",
                 i, DEV_CS, DEV_AD, DEV_DO, BUSY, DEV_WR, 4'(i));
      end
      busy_cnt = 1;
      wr_cnt   = 0;
      repeat (5) begin
        tick();
        busy_cnt += int'(BUSY);
        wr_cnt   += int'(DEV_WR);
      end
      vectors++;
      if (busy_cnt != 4 || wr_cnt != 2) begin
        miscompares++;
        $display("FAIL write_pulse[%0d]: busy_cycles=%0d wr_cycles=%0d, expected 4 2", i, busy_cnt, wr_cnt);
      end
    end
  endtask

  task automatic do_read(input logic [7:0] c, input logic [7:0] exp);
    int rd_cnt;
    logic [3:0] m;
    m = c[3:0];
    ctl_write(c);
    CS_DAT = 1'b1; RD = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (DEV_CS !== m || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL read_setup[%h]: cs=%h busy=%b, expected %h 1", c, DEV_CS, BUSY, m);
    end
    rd_cnt = 0;
    repeat (5) begin
      tick();
      rd_cnt += int'(DEV_RD);
    end
    CS_DAT = 1'b1; RD = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (DO !== exp || rd_cnt != 2) begin
      miscompares++;
      $display("FAIL read_data[%h]: do=%h rd_cycles=%0d, expected %h 2", c, DO, rd_cnt, exp);
    end
    repeat (5) tick();
  endtask

  task automatic test_read();
    DEV_DI0 = 8'h3C; DEV_DI1 = 8'h55; DEV_DI2 = 8'hAA; DEV_DI3 = 8'h0F;
    do_read(8'h13, 8'h3C);
    do_read(8'h1A, 8'h55);
    do_read(8'h1C, 8'hAA);
    do_read(8'h18, 8'h0F);
  endtask

  task automatic test_zero_mask();
    ctl_write(8'h10);
    CS_DAT = 1'b1; RD = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (DO !== 8'hFF || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_mask: do=%h busy=%b, expected ff 0", DO, BUSY);
    end
  endtask

  task automatic test_same_cycle();
    CS_CTL = 1'b1; CS_DAT = 1'b1; WR = 1'b1; DI = 8'h01;
    tick();
    idle_inputs();
    tick();
    vectors++;
    if (BUSY !== 1'b0 || DEV_CS !== 4'h0) begin
      miscompares++;
      $display("FAIL ctl_wins: busy=%b cs=%h, expected 0 0", BUSY, DEV_CS);
    end
  endtask

  task automatic test_idx_wrap();
    ctl_write(8'h01);
    for (int n = 0; n < 17; n++) begin
      dat_write(8'h00);
      vectors++;
      if (DEV_AD !== 4'(n % 16)) begin
        miscompares++;
        $display("FAIL idx_seq[%0d]: ad=%h expected %h", n, DEV_AD, 4'(n % 16));
      end
      repeat (4) tick();
    end
  endtask

  task automatic test_abort();
    ctl_write(8'h01);
    dat_write(8'h11);
    repeat (4) tick();
    dat_write(8'hA5);
    CS_DAT = 1'b1; WR = 1'b1; DI = 8'h5A;
    tick();
    idle_inputs();
    vectors++;
    if (DEV_WR !== 1'b1 || DEV_DO !== 8'hA5 || DEV_AD !== 4'h1) begin
      miscompares++;
      $display("FAIL busy_drop: wr=%b ddo=%h ad=%h, expected 1 a5 1", DEV_WR, DEV_DO, DEV_AD);
    end
    ctl_write(8'h01);
    vectors++;
    if (DEV_WR !== 1'b0 || BUSY !== 1'b0 || DEV_CS !== 4'h0) begin
      miscompares++;
      $display("FAIL abort: wr=%b busy=%b cs=%h, expected 0 0 0", DEV_WR, BUSY, DEV_CS);
    end
    repeat (3) tick();
    vectors++;
    if (BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL no_queue: busy=%b expected 0", BUSY);
    end
    dat_write(8'h77);
    vectors++;
    if (DEV_AD !== 4'h0 || DEV_DO !== 8'h77) begin
      miscompares++;
      $display("FAIL abort_idx: ad=%h ddo=%h, expected 0 77", DEV_AD, DEV_DO);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    ctl_write(8'h01);
    dat_write(8'hC3);
    tick();
    #2;
    RESET_N = 1'b0;
    #1;
    vectors++;
    if (DEV_WR !== 1'b0 || BUSY !== 1'b0 || DEV_CS !== 4'h0 || DEV_AD !== 4'h0 ||
        DEV_DO !== 8'h00 || DO !== 8'hFF || NMI !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: wr=%b busy=%b cs=%h ad=%h ddo=%h do=%h nmi=%b, expected 0 0 0 0 00 ff 0",
               DEV_WR, BUSY, DEV_CS, DEV_AD, DEV_DO, DO, NMI);
    end
    tick();
    RESET_N = 1'b1;
    CS_CTL = 1'b1; RD = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if (DO !== RB_AFTER_RESET || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_readback: do=%h busy=%b, expected %h 0", DO, BUSY, RB_AFTER_RESET);
    end
  endtask

  task automatic test_nmi_off();
    int highs;
    highs = 0;
    ctl_write(8'h10);
    repeat (2500) begin
      tick();
      highs += int'(NMI);
    end
    ctl_write(8'h01);
    repeat (2500) begin
      tick();
      highs += int'(NMI);
    end
    vectors++;
    if (highs != 0) begin
      miscompares++;
      $display("FAIL nmi_off: nmi high %0d cycles, expected 0", highs);
    end
  endtask

  task automatic test_nmi_restart();
    int highs;
    highs = 0;
    ctl_write(8'h21);
    repeat (1000) tick();
    ctl_write(8'h21);
    for (int c = 1; c <= 2400; c++) begin
      tick();
      if (c < 2400) highs += int'(NMI);
    end
    vectors++;
    if (highs != 0 || NMI !== 1'b1) begin
      miscompares++;
      $display("FAIL nmi_restart: early_highs=%0d nmi@2400=%b, expected 0 1", highs, NMI);
    end
  endtask

  task automatic test_nmi_period();
    int   err;
    logic exp;
    err = 0;
    ctl_write(8'h71);
    for (int c = 1; c <= 14600; c++) begin
      tick();
      exp = (c >= 7200) && ((c % 7200) < 200);
      if (NMI !== exp) err++;
      if (c == 7199 || c == 7200 || c == 7399 || c == 7400 || c == 14400) begin
        vectors++;
        if (NMI !== exp) begin
          miscompares++;
          $display("FAIL nmi_edge[%0d]: nmi=%b expected %b", c, NMI, exp);
        end
      end
    end
    vectors++;
    if (err != 0) begin
      miscompares++;
      $display("FAIL nmi_waveform: %0d cycles wrong, expected 0", err);
    end
  endtask

  initial begin
    DEV_DI0 = 8'h00; DEV_DI1 = 8'h00; DEV_DI2 = 8'h00; DEV_DI3 = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_zero_mask();
    test_same_cycle();
    test_idx_wrap();
    test_abort();
    test_reset_mid();
    test_nmi_off();
    test_nmi_restart();
    test_nmi_period();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
